sccb_wr_ctrl: RTL and testbench
===============================

SCCB_WR_CTRL -- requirements
Module: sccb_wr_ctrl

Interface
REQ-001 SHALL have parameter SYS_CLK_FREQ, default 50_000_000, sys_clk frequency in Hz.
REQ-002 SHALL have parameter SCL_FREQ, default 250_000, SCCB clock frequency in Hz.
REQ-003 SHALL have parameter DEV_ADDR, default 8'h42, 8-bit camera write ID, LSB 0.
REQ-004 SHALL have port sys_clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port sys_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port cfg_start  input  1  one-cycle request to write one register.
REQ-007 SHALL have port cfg_data  input  16  {reg_addr[15:8], reg_val[7:0]}.
REQ-008 SHALL have port cfg_end  output  1  one-cycle pulse when a transaction completes.
REQ-009 SHALL have port busy  output  1  high from request acceptance through the cfg_end cycle.
REQ-010 SHALL have port ack_err  output  1  sticky NACK flag; behaviour per REQ-031/032.
REQ-011 SHALL have port sccb_scl  output  1  SCCB clock.
REQ-012 SHALL have port sda_o  output  1  SDA drive value.
REQ-013 SHALL have port sda_oe  output  1  SDA drive enable; SDA released when 0.
REQ-014 SHALL have port sda_i  input  1  sampled SDA pad value.

Function
REQ-015 SHALL generate a quarter-bit tick every Q = SYS_CLK_FREQ/(4*SCL_FREQ) sys_clk cycles (50 at defaults); the counter restarts at 0 on request acceptance.
REQ-016 SHALL run an FSM with states IDLE, START, ID, ACK1, ADDR, ACK2, DATA, ACK3, STOP.
REQ-017 In IDLE, cfg_start=1 SHALL latch cfg_data, set busy, and move to START; cfg_start outside IDLE SHALL be ignored and SHALL NOT alter latched data.
REQ-018 START and STOP SHALL each last 4 quarters, each of the 8 bit periods of ID/ADDR/DATA 4 quarters, and each ACK state 4 quarters, giving 116 quarters per transaction.
REQ-019 START: quarters 0-1 SDA=1 and SCL=1; quarter 2 SDA=0 with SCL=1; quarter 3 SCL=0.
REQ-020 Data bits SHALL be sent MSB first: SDA updated at quarter 0 with SCL=0, SCL=1 in quarters 1-2, SCL=0 in quarter 3.
REQ-021 ID SHALL send DEV_ADDR, ADDR SHALL send cfg_data[15:8], and DATA SHALL send cfg_data[7:0].
REQ-022 ACK states SHALL hold sda_oe=0 with the same SCL pattern as data bits, sampling sda_i at the start of quarter 2.
REQ-023 STOP: quarter 0 SDA=0 and SCL=0; quarter 1 SCL=1; quarters 2-3 SDA=1 and SCL=1.
REQ-024 cfg_end SHALL be high exactly in cycle 116*Q after the acceptance edge (5800 at defaults); busy SHALL fall in the following cycle and the FSM SHALL be in IDLE.
REQ-025 A cfg_start coincident with the cfg_end cycle SHALL be ignored; one asserted in the first IDLE cycle after it SHALL be accepted.
REQ-026 sda_o=1 SHALL be driven as sda_oe=0 (open-drain); sda_oe=1 only while driving 0.
REQ-027 In IDLE: sccb_scl=1, sda_oe=0, cfg_end=0.

Reset
REQ-028 sys_rst SHALL force IDLE, tick and bit counters to 0, busy=0, cfg_end=0, ack_err=0, sccb_scl=1, sda_oe=0, and sda_o=1.
REQ-029 Reset mid-transaction SHALL abort without STOP and without a cfg_end pulse, with outputs reaching reset values on the next edge.
REQ-030 The first cfg_start accepted SHALL be one arriving in the cycle after sys_rst deasserts.

Configuration
REQ-031 With SCCB_ACK_CHK_EN defined, sda_i=1 sampled in any ACK state SHALL set ack_err and jump to STOP at the next quarter boundary; STOP SHALL complete normally and cfg_end SHALL pulse; ack_err SHALL clear on the next acceptance.
REQ-032 Without SCCB_ACK_CHK_EN, sda_i SHALL be ignored (SCCB don't-care bit), ack_err SHALL be constant 0, and timing SHALL always be 116 quarters.

Structure
REQ-033 Package sccb_pkg SHALL hold the FSM state enum, default SYS_CLK_FREQ/SCL_FREQ/DEV_ADDR constants, and the quarter-count constants (4 per bit, 116 per transaction).
REQ-034 Quarter-tick generation SHALL be one sub-module, sccb_qtr_tick, with ports sys_clk, sys_rst, clear, and tick.

Verification
REQ-035 cfg_data=16'h3d03, sda_i=0 -> SDA bytes 42,3d,03 MSB first, START/STOP shapes per REQ-019/023, cfg_end at cycle 5800, ack_err=0.
REQ-036 cfg_start at cycle 100 during a 16'h1502 transaction with cfg_data=16'hffff -> ignored; bytes 42,15,02 sent; a single cfg_end.
REQ-037 Three back-to-back requests 16'h1723, 16'h18a0, 16'h1907, each issued one cycle after the previous cfg_end -> three 5800-cycle transactions, no gaps beyond 1 cycle, SCL idle high between them.
REQ-038 sys_rst asserted at cycle 2000 of a 16'h3d03 transaction -> next edge: scl=1, sda_oe=0, busy=0; no cfg_end; a following request completes normally.
REQ-039 With SCCB_ACK_CHK_EN, sda_i=1 during ACK1 -> ack_err=1, STOP follows ACK1, cfg_end at cycle (4+36+4)*50=2200; without the macro -> full 5800-cycle transaction and ack_err=0.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB register-write controller.
package sccb_pkg;

    localparam int unsigned SCCB_SYS_CLK_FREQ = 50_000_000;
    localparam int unsigned SCCB_SCL_FREQ     = 250_000;
    localparam logic [7:0]  SCCB_DEV_ADDR     = 8'h42;

    localparam int unsigned QTR_PER_BIT  = 4;
    localparam int unsigned QTR_PER_XFER = 116;
    localparam int unsigned QTR_W        = $clog2(QTR_PER_BIT);
    localparam int unsigned BIT_W        = 3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ID,
        ST_ACK1,
        ST_ADDR,
        ST_ACK2,
        ST_DATA,
        ST_ACK3,
        ST_STOP
    } sccb_state_e;

    typedef struct packed {
        logic scl;
        logic sda;
    } sccb_drv_t;

    // Bus levels for a given state/quarter; sda=1 means released.
    function automatic sccb_drv_t sccb_drive(input sccb_state_e st,
                                             input logic [QTR_W-1:0] qtr,
                                             input logic bit_val);
        sccb_drv_t d;
        d.scl = 1'b1;
        d.sda = 1'b1;
        case (st)
            ST_START: begin
                d.scl = (qtr != QTR_W'(3));
                d.sda = (qtr <  QTR_W'(2));
            end
            ST_ID, ST_ADDR, ST_DATA: begin
                d.scl = (qtr == QTR_W'(1)) || (qtr == QTR_W'(2));
                d.sda = bit_val;
            end
            ST_ACK1, ST_ACK2, ST_ACK3: begin
                d.scl = (qtr == QTR_W'(1)) || (qtr == QTR_W'(2));
                d.sda = 1'b1;
            end
            ST_STOP: begin
                d.scl = (qtr != QTR_W'(0));
                d.sda = (qtr >= QTR_W'(2));
            end
            default: begin
                d.scl = 1'b1;
                d.sda = 1'b1;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/sccb_qtr_tick.sv
// Quarter-bit strobe: tick is high for one cycle every QTR_CYC cycles,
// with the phase restarted by clear.
module sccb_qtr_tick #(
    parameter int unsigned QTR_CYC = 50
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned        CNT_W    = (QTR_CYC > 1) ? $clog2(QTR_CYC) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(QTR_CYC - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_tick;

    always_comb begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (clear || (r_cnt == CNT_LAST)) begin
            w_cnt_nxt = '0;
        end
    end

    // tick is registered so it is high exactly while the counter sits at its last value
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_tick <= (w_cnt_nxt == CNT_LAST);
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/sccb_wr_ctrl.sv
// SCCB 3-phase register write master (ID, address, data) with registered bus outputs.
// Optional NACK detection with early STOP is enabled by defining SCCB_ACK_CHK_EN.
module sccb_wr_ctrl
    import sccb_pkg::*;
#(
    parameter int unsigned SYS_CLK_FREQ = SCCB_SYS_CLK_FREQ,
    parameter int unsigned SCL_FREQ     = SCCB_SCL_FREQ,
    parameter logic [7:0]  DEV_ADDR     = SCCB_DEV_ADDR
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        cfg_start,
    input  logic [15:0] cfg_data,
    output logic        cfg_end,
    output logic        busy,
    output logic        ack_err,
    output logic        sccb_scl,
    output logic        sda_o,
    output logic        sda_oe,
    input  logic        sda_i
);

    localparam int unsigned        QTR_CYC  = SYS_CLK_FREQ / (4 * SCL_FREQ);
    localparam logic [QTR_W-1:0]   QTR_LAST = QTR_W'(QTR_PER_BIT - 1);
    localparam logic [BIT_W-1:0]   BIT_LAST = BIT_W'(7);

    sccb_state_e      r_state;
    sccb_state_e      w_state_nxt;
    logic [QTR_W-1:0] r_qtr;
    logic [QTR_W-1:0] w_qtr_nxt;
    logic [BIT_W-1:0] r_bit;
    logic [BIT_W-1:0] w_bit_nxt;
    logic [15:0]      r_data;
    logic             r_busy;
    logic             r_cfg_end;
    logic             r_scl;
    logic             r_sda_o;
    logic             r_sda_oe;
    logic             w_tick;
    logic             w_acc;
    logic             w_nack;
    logic [7:0]       w_byte;
    logic             w_bit_val;
    sccb_drv_t        w_drv;

    sccb_qtr_tick #(
        .QTR_CYC (QTR_CYC)
    ) u_qtr_tick (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clear   (w_acc),
        .tick    (w_tick)
    );

    // busy still high in the first IDLE cycle blocks a request coincident with cfg_end
    assign w_acc = (r_state == ST_IDLE) && !r_busy && cfg_start;

    always_comb begin
        w_state_nxt = r_state;
        w_qtr_nxt   = r_qtr;
        w_bit_nxt   = r_bit;
        if (r_state == ST_IDLE) begin
            if (w_acc) begin
                w_state_nxt = ST_START;
                w_qtr_nxt   = '0;
                w_bit_nxt   = '0;
            end
        end else if (w_tick) begin
            w_qtr_nxt = r_qtr + QTR_W'(1);
            if (r_qtr == QTR_LAST) begin
                case (r_state)
                    ST_START: w_state_nxt = ST_ID;
                    ST_ID, ST_ADDR, ST_DATA: begin
                        if (r_bit == BIT_LAST) begin
                            w_bit_nxt = '0;
                            if (r_state == ST_ID) begin
                                w_state_nxt = ST_ACK1;
                            end else if (r_state == ST_ADDR) begin
                                w_state_nxt = ST_ACK2;
                            end else begin
                                w_state_nxt = ST_ACK3;
                            end
                        end else begin
                            w_bit_nxt = r_bit + BIT_W'(1);
                        end
                    end
                    ST_ACK1: w_state_nxt = w_nack ? ST_STOP : ST_ADDR;
                    ST_ACK2: w_state_nxt = w_nack ? ST_STOP : ST_DATA;
                    ST_ACK3: w_state_nxt = ST_STOP;
                    ST_STOP: w_state_nxt = ST_IDLE;
                    default: w_state_nxt = ST_IDLE;
                endcase
            end
        end
    end

    // Outputs are derived from the next state so they register in step with it.
    always_comb begin
        w_byte = 8'hff;
        case (w_state_nxt)
            ST_ID:   w_byte = DEV_ADDR;
            ST_ADDR: w_byte = r_data[15:8];
            ST_DATA: w_byte = r_data[7:0];
            default: w_byte = 8'hff;
        endcase
        w_bit_val = w_byte[BIT_LAST - w_bit_nxt];
        w_drv     = sccb_drive(w_state_nxt, w_qtr_nxt, w_bit_val);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= ST_IDLE;
            r_qtr     <= '0;
            r_bit     <= '0;
            r_data    <= '0;
            r_busy    <= 1'b0;
            r_cfg_end <= 1'b0;
            r_scl     <= 1'b1;
            r_sda_o   <= 1'b1;
            r_sda_oe  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_qtr     <= w_qtr_nxt;
            r_bit     <= w_bit_nxt;
            r_scl     <= w_drv.scl;
            r_sda_o   <= w_drv.sda;
            r_sda_oe  <= !w_drv.sda;
            r_cfg_end <= (r_state == ST_STOP) && w_tick && (r_qtr == QTR_LAST);
            if (w_acc) begin
                r_data <= cfg_data;
                r_busy <= 1'b1;
            end else if (r_state == ST_IDLE) begin
                r_busy <= 1'b0;
            end
        end
    end

`ifdef SCCB_ACK_CHK_EN
    logic r_ack_err;
    logic w_ack_smp;

    // Acknowledge is sampled entering quarter 2, while SCL is high.
    assign w_ack_smp = ((r_state == ST_ACK1) || (r_state == ST_ACK2) || (r_state == ST_ACK3))
                       && w_tick && (r_qtr == QTR_W'(1));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_ack_err <= 1'b0;
        end else if (w_acc) begin
            r_ack_err <= 1'b0;
        end else if (w_ack_smp && sda_i) begin
            r_ack_err <= 1'b1;
        end
    end

    assign w_nack  = r_ack_err;
    assign ack_err = r_ack_err;
`else
    logic w_sda_unused;

    assign w_sda_unused = sda_i;
    assign w_nack       = 1'b0;
    assign ack_err      = 1'b0;
`endif

    assign cfg_end  = r_cfg_end;
    assign busy     = r_busy;
    assign sccb_scl = r_scl;
    assign sda_o    = r_sda_o;
    assign sda_oe   = r_sda_oe;

endmodule

// File: tb/tb_sccb_wr_ctrl.sv
// Directed bench for sccb_wr_ctrl: decodes the SCCB bus and checks waveform, bytes and timing.
module tb_sccb_wr_ctrl;

    localparam int         Q      = 50;
    localparam int         XFER   = 116 * Q;
    localparam int         LIMIT  = 6000;
    localparam logic [7:0] DEV_TB = 8'h42;
`ifdef SCCB_ACK_CHK_EN
    localparam bit ACK_CHK = 1'b1;
`else
    localparam bit ACK_CHK = 1'b0;
`endif

    logic        sys_clk;
    logic        sys_rst;
    logic        cfg_start;
    logic [15:0] cfg_data;
    logic        cfg_end;
    logic        busy;
    logic        ack_err;
    logic        sccb_scl;
    logic        sda_o;
    logic        sda_oe;
    logic        sda_i;

    int n_cmp = 0;
    int n_err = 0;

    sccb_wr_ctrl #(
        .SYS_CLK_FREQ (50_000_000),
        .SCL_FREQ     (250_000),
        .DEV_ADDR     (DEV_TB)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .cfg_start (cfg_start),
        .cfg_data  (cfg_data),
        .cfg_end   (cfg_end),
        .busy      (busy),
        .ack_err   (ack_err),
        .sccb_scl  (sccb_scl),
        .sda_o     (sda_o),
        .sda_oe    (sda_oe),
        .sda_i     (sda_i)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference {scl, sda line} k cycles after acceptance, built from the quarter table.
    function automatic logic [1:0] exp_wave(input int k, input logic [27:0] bits);
        int qi;
        int q;
        int slot;
        qi = k / Q;
        q  = qi % 4;
        if (qi < 4) begin
            return {1'(q != 3), 1'(q < 2)};
        end else if (qi < 112) begin
            slot = (qi - 4) / 4;
            return {1'((q == 1) || (q == 2)), bits[27 - slot]};
        end else begin
            q = qi - 112;
            return {1'(q != 0), 1'(q >= 2)};
        end
    endfunction

    task automatic run_xfer(input logic [15:0] d, input int poke_k, input int rst_k,
                            input bit nack, input bit pulse_on_end, input string tag);
        logic [27:0] exp_bits;
        logic [27:0] shreg;
        logic [1:0]  ew;
        logic        prev_scl;
        logic        prev_line;
        logic        line;
        bit          early;
        int          exp_k;
        int          nbits;
        int          starts;
        int          stops;
        int          shape_err;
        int          end_k;
        int          n_hi;
        exp_bits  = {DEV_TB, 1'b1, d[15:8], 1'b1, d[7:0], 1'b1, 1'b0};
        early     = nack && ACK_CHK;
        exp_k     = early ? (4 + 36 + 4) * Q : XFER;
        shreg     = '0;
        nbits     = 0;
        starts    = 0;
        stops     = 0;
        shape_err = 0;
        end_k     = -1;
        prev_scl  = 1'b1;
        prev_line = 1'b1;
        sda_i     = nack;
        cfg_data  = d;
        cfg_start = 1'b1;
        @(negedge sys_clk);
        cfg_start = 1'b0;
        for (int k = 0; k <= LIMIT; k++) begin
            if (k > 0) @(negedge sys_clk);
            if (rst_k >= 0 && k == rst_k + 1) begin
                chk_eq({tag, " rst outs"}, 32'({sccb_scl, sda_oe, sda_o, busy, cfg_end}), 32'h14);
                sys_rst = 1'b0;
                sda_i   = 1'b0;
                n_hi    = 0;
                repeat (4000) begin
                    @(negedge sys_clk);
                    if (cfg_end || busy) n_hi++;
                end
                chk_eq({tag, " post-rst quiet"}, n_hi, 0);
                return;
            end
            line = sda_oe ? 1'b0 : 1'b1;
            if (!prev_scl && sccb_scl) begin
                shreg = {shreg[26:0], line};
                nbits++;
            end
            if (prev_scl && sccb_scl && prev_line && !line) starts++;
            if (prev_scl && sccb_scl && !prev_line && line) stops++;
            prev_scl  = sccb_scl;
            prev_line = line;
            if (!early && k < XFER) begin
                ew = exp_wave(k, exp_bits);
                if ({sccb_scl, line} != ew) shape_err++;
            end
            if (sda_oe == sda_o) shape_err++;
            if (!busy) shape_err++;
            if (cfg_end) begin
                end_k = k;
                break;
            end
            if (k == poke_k) begin
                cfg_start = 1'b1;
                cfg_data  = 16'hffff;
            end else if (k == poke_k + 1) begin
                cfg_start = 1'b0;
            end
            if (k == rst_k) sys_rst = 1'b1;
        end
        sda_i = 1'b0;
        chk_eq({tag, " cfg_end cycle"}, end_k, exp_k);
        chk_eq({tag, " waveform errs"}, shape_err, 0);
        chk_eq({tag, " scl-rise bits"}, 32'(shreg),
               early ? 32'({DEV_TB, 1'b1, 1'b0}) : 32'(exp_bits));
        chk_eq({tag, " bit count"}, nbits, early ? 10 : 28);
        chk_eq({tag, " start/stop"}, starts * 256 + stops, 257);
        chk_eq({tag, " ack_err"}, 32'(ack_err), 32'(early));
        if (pulse_on_end) begin
            cfg_start = 1'b1;
            cfg_data  = 16'h0000;
        end
        @(negedge sys_clk);
        cfg_start = 1'b0;
        chk_eq({tag, " idle after end"}, 32'({busy, cfg_end, sccb_scl, sda_oe}), 32'h2);
    endtask

    initial begin
        int n_hi;
        sys_rst   = 1'b1;
        cfg_start = 1'b1;
        cfg_data  = 16'h1234;
        sda_i     = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk_eq("reset outs", 32'({sccb_scl, sda_oe, sda_o, busy, cfg_end, ack_err}), 32'h28);
        sys_rst = 1'b0;

        run_xfer(16'h3d03, -1, -1, 1'b0, 1'b0, "x3d03");

        run_xfer(16'h1502, 100, -1, 1'b0, 1'b0, "x1502 poke");
        n_hi = 0;
        repeat (300) begin
            @(negedge sys_clk);
            if (cfg_end || busy) n_hi++;
        end
        chk_eq("x1502 no second end", n_hi, 0);

        run_xfer(16'h1723, -1, -1, 1'b0, 1'b1, "b2b 1723");
        run_xfer(16'h18a0, -1, -1, 1'b0, 1'b1, "b2b 18a0");
        run_xfer(16'h1907, -1, -1, 1'b0, 1'b0, "b2b 1907");

        run_xfer(16'h3d03, -1, 2000, 1'b0, 1'b0, "abort");
        run_xfer(16'h3d03, -1, -1, 1'b0, 1'b0, "after abort");

        run_xfer(16'h1111, -1, -1, 1'b1, 1'b0, "nack");
        run_xfer(16'h2233, -1, -1, 1'b0, 1'b0, "after nack");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
